// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, issues pipelined word fetches and buffers
// returned instructions with their PCs in a prefetch queue consumed by decode.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        req_valid,
    input  logic        req_ready,
    output logic [31:0] req_addr,
    input  logic        rsp_valid,
    input  logic [31:0] rsp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW:0]   DEPTH_W = (CW + 1)'(DEPTH);
    localparam logic [CW-1:0] C_ONE   = CW'(1);
    localparam logic [PW-1:0] P_ONE   = PW'(1);

    logic [31:0]   r_fetchPc;
    logic [31:0]   r_qPc   [DEPTH];
    logic [31:0]   r_qInst [DEPTH];
    logic [31:0]   r_tagPc [DEPTH];
    logic [PW-1:0] r_rdPtr;
    logic [PW-1:0] r_wrPtr;
    logic [PW-1:0] r_tagRd;
    logic [PW-1:0] r_tagWr;
    logic [CW-1:0] r_count;
    logic [CW-1:0] r_inflight;
    logic [CW-1:0] r_drop;

    logic          w_credit;
    logic          w_reqFire;
    logic          w_pop;
    logic          w_push;
    logic [CW-1:0] w_rspDec;

    // Queue slots already promised to outstanding requests count against credit.
    assign w_credit   = ({1'b0, r_count} + {1'b0, r_inflight}) < DEPTH_W;
    assign req_valid  = !rst && !redirect_valid && w_credit;
    assign req_addr   = r_fetchPc;
    assign inst_valid = (r_count != '0) && !redirect_valid;
    assign inst       = r_qInst[r_rdPtr];
    assign inst_pc    = r_qPc[r_rdPtr];

    assign w_reqFire  = req_valid && req_ready;
    assign w_pop      = inst_valid && inst_ready;
    assign w_push     = rsp_valid && (r_drop == '0) && !redirect_valid;
    assign w_rspDec   = rsp_valid ? C_ONE : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetchPc  <= RESET_PC;
            r_rdPtr    <= '0;
            r_wrPtr    <= '0;
            r_tagRd    <= '0;
            r_tagWr    <= '0;
            r_count    <= '0;
            r_inflight <= '0;
            r_drop     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_qPc[i]   <= '0;
                r_qInst[i] <= '0;
                r_tagPc[i] <= '0;
            end
        end else begin
            r_inflight <= r_inflight + (w_reqFire ? C_ONE : '0) - w_rspDec;
            if (rsp_valid) begin
                r_tagRd <= r_tagRd + P_ONE;
            end
            if (w_reqFire) begin
                r_tagPc[r_tagWr] <= r_fetchPc;
                r_tagWr          <= r_tagWr + P_ONE;
            end

            // A response landing in the redirect cycle is itself stale, so it
            // is excluded from the drop count and simply not written.
            if (redirect_valid) begin
                r_fetchPc <= redirect_pc & 32'hFFFF_FFFC;
                r_count   <= '0;
                r_rdPtr   <= '0;
                r_wrPtr   <= '0;
                r_drop    <= r_inflight - w_rspDec;
            end else begin
                if (w_reqFire) begin
                    r_fetchPc <= r_fetchPc + 32'd4;
                end
                if (rsp_valid && (r_drop != '0)) begin
                    r_drop <= r_drop - C_ONE;
                end
                if (w_push) begin
                    r_qPc[r_wrPtr]   <= r_tagPc[r_tagRd];
                    r_qInst[r_wrPtr] <= rsp_data;
                    r_wrPtr          <= r_wrPtr + P_ONE;
                end
                if (w_pop) begin
                    r_rdPtr <= r_rdPtr + P_ONE;
                end
                r_count <= r_count + (w_push ? C_ONE : '0) - (w_pop ? C_ONE : '0);
            end
        end
    end

endmodule

// File: doc/ifu_fetch.md
# ifu_fetch

Instruction fetch unit for the npc core. It owns the PC register, issues word fetches to instruction memory over a valid/ready request channel, and buffers returned instructions with their PCs in a DEPTH-entry prefetch queue. Decode consumes the queue through a valid/ready handshake. A redirect (taken branch, jal, jalr) flushes the queue and discards in-flight responses. It replaces the always-+4 PC register and combinational instruction ROM of the single-cycle datapath, and adds pipelined, multi-outstanding fetch.

## Interface
- RESET_PC, 32'h80000000, first fetch address after reset
- DEPTH, 4, prefetch queue entries and maximum outstanding requests; power of two, >= 2
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  out  1  fetch request valid
- req_ready  in  1  memory accepts request
- req_addr  out  32  fetch address, word aligned
- rsp_valid  in  1  response beat; in order, one per accepted request, never before the accepting cycle's next edge
- rsp_data  in  32  instruction word
- inst_valid  out  1  queue head valid to decode
- inst_ready  in  1  decode accepts head
- inst  out  32  head instruction
- inst_pc  out  32  head PC
- redirect_valid  in  1  flush and restart fetch
- redirect_pc  in  32  new fetch PC; bits [1:0] ignored (treated as 0)

## Operation
- State: fetch_pc (32b), queue (DEPTH x {pc, inst}, rd/wr pointers, count), inflight counter (requests accepted, response pending), drop counter (pending responses to discard), pc_tag FIFO of issued addresses (DEPTH entries) pairing responses with PCs.
- Counters are $clog2(DEPTH+1) bits wide. Invariant: count + inflight <= DEPTH. drop <= inflight.
- Issue: req_valid = !redirect_valid && (count + inflight < DEPTH); req_addr = fetch_pc. Request stability is not required. Memory samples only on req_valid && req_ready.
- On request handshake: fetch_pc += 4 (mod 2^32), inflight += 1, push fetch_pc to pc_tag.
- Response: rsp_valid is always accepted (no backpressure). inflight -= 1, pop pc_tag. If drop > 0, drop -= 1 and the data is discarded. Otherwise write {tag pc, rsp_data} to the queue.
- Output: inst_valid = (count != 0) && !redirect_valid; inst/inst_pc = head entry. Pop on inst_valid && inst_ready.
- Redirect (redirect_valid=1), highest priority:
  - fetch_pc <= {redirect_pc[31:2], 2'b00}.
  - Queue count and pointers are cleared.
  - Consumer pop is suppressed.
  - Nothing is written to the queue.
  - drop <= inflight minus 1 if a response arrives in the same cycle; that response is discarded.
  - No request is issued in the redirect cycle.
- Back-to-back redirects: the last one wins. drop is recomputed from current inflight each time, so it stays correct.
- Simultaneous push and pop: count unchanged. Queue full (count == DEPTH) with inflight == 0 is legal; issue stalls.

## Timing
- Reset values: fetch_pc = RESET_PC; count = inflight = drop = 0; pointers 0; req_valid = 1 from the first cycle after rst deasserts (0 during reset); inst_valid = 0; req_addr = RESET_PC; inst/inst_pc = 0.
- Reset mid-operation clears all counters immediately. Memory responses to pre-reset requests are the memory's responsibility to squash.
- Issue throughput: 1 request/cycle while credit remains.
- Response latency to consumer: response at edge t is written at t and inst_valid is high at t+1. There is no same-cycle bypass.
- Redirect at edge t: first request to the new PC can be accepted at t+1; inst_valid is low during t and t+1 at minimum.
- Steady state with 1-cycle memory and inst_ready=1: one instruction per cycle, PCs consecutive by 4.

## Test plan
- Reset release, req_ready=1, 1-cycle memory returning addr^32'hFFFF_FFFF -> inst_pc sequence 80000000, 80000004, 80000008…, each inst matching, inst_valid first high 2 cycles after reset release, then continuous.
- inst_ready=0, DEPTH=4 -> exactly 4 requests accepted (80000000…8000000C), req_valid then low. After one pop, one new request to 80000010.
- 3 requests in flight (3-cycle memory), redirect_pc=80000103 -> next req_addr=80000100, 3 stale responses dropped, first inst_pc out=80000100.
- Redirect in the same cycle as a response and a consumer pop -> that response dropped, pop not counted, queue empty next cycle, drop = inflight-1.
- Two consecutive redirect cycles (A=80001000, then B=80002000) with 2 in flight -> only B's stream appears, no A-stream or stale instruction is delivered.
- fetch_pc=FFFFFFFC after redirect -> next req_addr wraps to 00000000. Assert rst mid-stream -> all outputs return to reset values asynchronously.
